// File: rtl/hlsm6_job_sequencer_pkg.sv
// rtl/hlsm6_job_sequencer_pkg.sv - shared types and constants for the HLSM6 job sequencer
// Contents: FSM state enum, status bit indices, default KERN_LAT/TIMEOUT/TAG_W, data width.
package hlsm_seq_pkg;

    localparam int DATA_W       = 16;
    localparam int KERN_LAT_DEF = 5;
    localparam int TIMEOUT_DEF  = 64;
    localparam int TAG_W_DEF    = 4;

    // Bit positions inside out_status
    localparam int ST_DIV0    = 0;
    localparam int ST_TIMEOUT = 1;

    typedef logic signed [DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RECOVER,
        S_OUT
    } seq_state_e;

endpackage

// File: rtl/hlsm6_job_sequencer_if.sv
// rtl/hlsm6_job_sequencer_if.sv - job input / result output handshake bundle
// Ports: in_valid/in_ready + in_a..in_g (job side), out_valid/out_ready + out_k/out_l/out_tag/out_status (result side).
// master = job producer / result consumer, slave = the sequencer.
interface hlsm6_job_sequencer_if #(
    parameter int TAG_W = hlsm_seq_pkg::TAG_W_DEF
);
    import hlsm_seq_pkg::*;

    logic             in_valid;
    logic             in_ready;
    word_t            in_a, in_b, in_c, in_d, in_e, in_f, in_g;
    logic             out_valid;
    logic             out_ready;
    word_t            out_k, out_l;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_status;

    modport master (
        output in_valid, in_a, in_b, in_c, in_d, in_e, in_f, in_g, out_ready,
        input  in_ready, out_valid, out_k, out_l, out_tag, out_status
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_d, in_e, in_f, in_g, out_ready,
        output in_ready, out_valid, out_k, out_l, out_tag, out_status
    );

endinterface

// File: rtl/hlsm6_job_sequencer_watchdog.sv
// rtl/hlsm6_job_sequencer_watchdog.sv - WAIT-state cycle counter with latency and timeout flags
// Ports: Clk, Rst (active-low async), clr, en -> lat_reached (cnt>=KERN_LAT), timeout (cnt==TIMEOUT).
module hlsm_seq_watchdog
    import hlsm_seq_pkg::*;
#(
    parameter int KERN_LAT = KERN_LAT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clr,
    input  logic en,
    output logic lat_reached,
    output logic timeout
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // The sequencer leaves WAIT at cnt==TIMEOUT, so cnt never exceeds TIMEOUT+1
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign lat_reached = (cnt >= CNT_W'(KERN_LAT));
    assign timeout     = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/hlsm6_job_sequencer.sv
// rtl/hlsm6_job_sequencer.sv - HLSM6 kernel front-end: job accept, start pulse, completion/timeout, result hold
// Ports: Clk, Rst (active-low async), job (slave handshake bundle),
//        kern_start/kern_rst/kern_a..kern_g to the kernel, kern_done/kern_k/kern_l from the kernel.
module hlsm6_job_sequencer
    import hlsm_seq_pkg::*;
#(
    parameter int KERN_LAT = KERN_LAT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int TAG_W    = TAG_W_DEF
) (
    input  logic                 Clk,
    input  logic                 Rst,
    hlsm6_job_sequencer_if.slave job,
    output logic                 kern_start,
    output logic                 kern_rst,
    output word_t                kern_a, kern_b, kern_c, kern_d, kern_e, kern_f, kern_g,
    input  logic                 kern_done,
    input  word_t                kern_k,
    input  word_t                kern_l
);
    seq_state_e       state, state_nxt;
    logic             rst_hold;
    logic             rec_cnt;
    logic             wd_clr, wd_en;
    logic             lat_reached, timeout;
    logic             accept, complete;
    logic [1:0]       status;
    logic [TAG_W-1:0] tag;
    word_t            res_k, res_l;

    hlsm_seq_watchdog #(
        .KERN_LAT(KERN_LAT),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .Clk        (Clk),
        .Rst        (Rst),
        .clr        (wd_clr),
        .en         (wd_en),
        .lat_reached(lat_reached),
        .timeout    (timeout)
    );

    assign accept   = job.in_valid & job.in_ready;
    // kern_done is sticky across jobs, so it only counts once the latency has elapsed
    assign complete = lat_reached & kern_done;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (complete)
                    state_nxt = S_OUT;
                else if (timeout)
                    state_nxt = S_RECOVER;
            end
            S_RECOVER: if (rec_cnt) state_nxt = S_OUT;
            S_OUT:     if (job.out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        job.in_ready  = (state == S_IDLE) && !rst_hold;
        job.out_valid = (state == S_OUT);
        kern_start    = (state == S_ISSUE);
        kern_rst      = rst_hold || (state == S_RECOVER);
        wd_clr        = (state == S_ISSUE);
        wd_en         = (state == S_WAIT);
    end

    // Holds the kernel in reset from Rst assertion until the first clock edge after release
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            rst_hold <= 1'b1;
        else
            rst_hold <= 1'b0;
    end

    // Two-cycle RECOVER timer
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            rec_cnt <= 1'b0;
        else if (state == S_RECOVER)
            rec_cnt <= ~rec_cnt;
        else
            rec_cnt <= 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            kern_a <= '0; kern_b <= '0; kern_c <= '0; kern_d <= '0;
            kern_e <= '0; kern_f <= '0; kern_g <= '0;
            res_k  <= '0;
            res_l  <= '0;
            status <= '0;
            tag    <= '0;
        end else begin
            if (accept) begin
                kern_a <= job.in_a; kern_b <= job.in_b; kern_c <= job.in_c; kern_d <= job.in_d;
                kern_e <= job.in_e; kern_f <= job.in_f; kern_g <= job.in_g;
                status <= '0;
                status[ST_DIV0] <= (job.in_e == '0) || (job.in_g == '0);
            end
            if (state == S_WAIT) begin
                if (complete) begin
                    res_k <= kern_k;
                    res_l <= kern_l;
                end else if (timeout) begin
                    res_k <= '0;
                    res_l <= '0;
                    status[ST_TIMEOUT] <= 1'b1;
                end
            end
            if ((state == S_OUT) && job.out_ready)
                tag <= tag + 1'b1;
        end
    end

    assign job.out_k      = res_k;
    assign job.out_l      = res_l;
    assign job.out_tag    = tag;
    assign job.out_status = status;

endmodule

// File: tb/tb_hlsm6_job_sequencer.sv
// tb/tb_hlsm6_job_sequencer.sv - self-checking bench for hlsm6_job_sequencer with a behavioural kernel
module tb_hlsm6_job_sequencer;
    import hlsm_seq_pkg::*;

    localparam int KL = 5;
    localparam int TO = 64;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    hlsm6_job_sequencer_if #(.TAG_W(4)) job_if();

    logic  kern_start, kern_rst, kern_done;
    word_t kern_a, kern_b, kern_c, kern_d, kern_e, kern_f, kern_g, kern_k, kern_l;

    hlsm6_job_sequencer #(.KERN_LAT(KL), .TIMEOUT(TO), .TAG_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .job(job_if),
        .kern_start(kern_start), .kern_rst(kern_rst),
        .kern_a(kern_a), .kern_b(kern_b), .kern_c(kern_c), .kern_d(kern_d),
        .kern_e(kern_e), .kern_f(kern_f), .kern_g(kern_g),
        .kern_done(kern_done), .kern_k(kern_k), .kern_l(kern_l)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Kernel arithmetic; this kernel returns -1 for a zero divisor
    function automatic word_t ref_k(input word_t a, b, c, d, e);
        int num;
        num = int'(a) * int'(b) + int'(c) * int'(d);
        if (e == 0) return -16'sd1;
        return word_t'(num / int'(e));
    endfunction

    function automatic word_t ref_l(input word_t f, g);
        if (g == 0) return -16'sd1;
        return word_t'(int'(f) / int'(g));
    endfunction

    // Behavioural kernel: done rises KL edges after Start is sampled, stays high until kern_rst
    bit    kern_hang = 1'b0;
    logic  kdone = 1'b0;
    int    kcd = 0;
    word_t kk = '0, kl = '0;
    always @(posedge Clk) begin
        if (kern_rst) begin
            kdone <= 1'b0;
            kcd   <= 0;
        end else if (kern_start) begin
            kcd <= KL;
        end else if (kcd > 0) begin
            kcd <= kcd - 1;
            if (kcd == 1) begin
                kdone <= 1'b1;
                kk    <= ref_k(kern_a, kern_b, kern_c, kern_d, kern_e);
                kl    <= ref_l(kern_f, kern_g);
            end
        end
    end
    assign kern_done = kdone & !kern_hang;
    assign kern_k    = kk;
    assign kern_l    = kl;

    // Scoreboard of expected results, one entry per accepted job
    typedef struct {
        word_t      k;
        word_t      l;
        logic [3:0] tag;
        logic [1:0] st;
    } exp_t;

    exp_t  q[$];
    exp_t  nx;
    int    mtag = 0;
    int    since_acc = -1;
    bit    have_ops = 1'b0;
    word_t ea, ee, eg;

    always @(negedge Clk) begin
        if (Rst) begin
            if (since_acc >= 0) since_acc++;
            check("kern_start_pulse", kern_start, since_acc == 1);
            if (have_ops) begin
                check("kern_a_hold", kern_a, ea);
                check("kern_e_hold", kern_e, ee);
                check("kern_g_hold", kern_g, eg);
            end
            if (job_if.in_valid && job_if.in_ready) begin
                ea = job_if.in_a; ee = job_if.in_e; eg = job_if.in_g;
                have_ops  = 1'b1;
                since_acc = 0;
                nx.k   = kern_hang ? word_t'(0) : ref_k(job_if.in_a, job_if.in_b, job_if.in_c, job_if.in_d, job_if.in_e);
                nx.l   = kern_hang ? word_t'(0) : ref_l(job_if.in_f, job_if.in_g);
                nx.tag = 4'(mtag);
                nx.st  = {kern_hang, (job_if.in_e == 0) || (job_if.in_g == 0)};
                mtag++;
                q.push_back(nx);
            end
            if (job_if.out_valid) begin
                check("in_ready_low_in_out", job_if.in_ready, 0);
                if (q.size() == 0) begin
                    check("spurious_out_valid", job_if.out_valid, 0);
                end else begin
                    check("out_k", job_if.out_k, q[0].k);
                    check("out_l", job_if.out_l, q[0].l);
                    check("out_tag", job_if.out_tag, q[0].tag);
                    check("out_status", job_if.out_status, q[0].st);
                    if (job_if.out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic run_job(input word_t a, b, c, d, e, f, g, input int stall,
                           output int lat, output int nrst,
                           output word_t rk, output word_t rl, output int rt, output int rs);
        int n;
        lat = 0; nrst = 0; rk = '0; rl = '0; rt = -1; rs = -1;
        job_if.out_ready = (stall == 0);
        job_if.in_a = a; job_if.in_b = b; job_if.in_c = c; job_if.in_d = d;
        job_if.in_e = e; job_if.in_f = f; job_if.in_g = g;
        job_if.in_valid = 1'b1;
        n = 0;
        while (!job_if.in_ready && n < 200) begin
            @(posedge Clk); #1; n++;
        end
        check("accept_wait_bound", n < 200, 1);
        @(posedge Clk); #1;
        job_if.in_valid = 1'b0;
        while (!job_if.out_valid && lat < 200) begin
            if (kern_rst) nrst++;
            @(posedge Clk); #1; lat++;
        end
        check("result_wait_bound", lat < 200, 1);
        rk = job_if.out_k; rl = job_if.out_l; rt = job_if.out_tag; rs = job_if.out_status;
        for (int i = 0; i < stall; i++) begin
            @(posedge Clk); #1;
            check("stall_out_valid", job_if.out_valid, 1);
            check("stall_in_ready", job_if.in_ready, 0);
            check("stall_k_stable", job_if.out_k, rk);
        end
        job_if.out_ready = 1'b1;
        @(posedge Clk); #1;
        check("out_valid_falls", job_if.out_valid, 0);
    endtask

    int    lat, nr, rt, rs;
    word_t rk, rl;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "time budget exceeded");
    end

    initial begin
        job_if.in_valid = 1'b0; job_if.out_ready = 1'b1;
        job_if.in_a = '0; job_if.in_b = '0; job_if.in_c = '0; job_if.in_d = '0;
        job_if.in_e = '0; job_if.in_f = '0; job_if.in_g = '0;
        Rst = 1'b1;
        #2 Rst = 1'b0;
        #1;
        check("rst_out_valid", job_if.out_valid, 0);
        check("rst_out_k", job_if.out_k, 0);
        check("rst_out_status", job_if.out_status, 0);
        check("rst_out_tag", job_if.out_tag, 0);
        check("rst_kern_start", kern_start, 0);
        check("rst_kern_a", kern_a, 0);
        check("rst_kern_rst", kern_rst, 1);
        check("rst_in_ready", job_if.in_ready, 0);
        @(negedge Clk); @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("rel_kern_rst_before_edge", kern_rst, 1);
        check("rel_in_ready_before_edge", job_if.in_ready, 0);
        @(posedge Clk); #1;
        check("rel_kern_rst_after_edge", kern_rst, 0);
        check("rel_in_ready_after_edge", job_if.in_ready, 1);

        run_job(3, 4, 5, 6, 7, 100, 9, 0, lat, nr, rk, rl, rt, rs);
        check("j1_lat", lat, 7); check("j1_k", rk, 6); check("j1_l", rl, 11);
        check("j1_tag", rt, 0); check("j1_st", rs, 0);

        run_job(-3, 4, 2, 1, 3, -7, 2, 0, lat, nr, rk, rl, rt, rs);
        check("j2_k", rk, -3); check("j2_l", rl, -3); check("j2_tag", rt, 1);

        for (int i = 0; i < 3; i++) begin
            run_job(word_t'(i + 1), 2, 3, 4, 2, -50, 7, (i == 1) ? 5 : 0, lat, nr, rk, rl, rt, rs);
            check("b2b_tag", rt, 2 + i);
            check("b2b_lat", lat, 7);
        end

        run_job(3, 4, 5, 6, 7, 100, 0, 0, lat, nr, rk, rl, rt, rs);
        check("div0_st", rs, 1); check("div0_k", rk, 6); check("div0_l", rl, -1);

        kern_hang = 1'b1;
        run_job(3, 4, 5, 6, 7, 100, 9, 0, lat, nr, rk, rl, rt, rs);
        kern_hang = 1'b0;
        check("to_lat", lat, 1 + TO + 1 + 2); check("to_kern_rst_cycles", nr, 2);
        check("to_st", rs, 2); check("to_k", rk, 0); check("to_l", rl, 0); check("to_tag", rt, 6);

        run_job(3, 4, 5, 6, 7, 100, 9, 0, lat, nr, rk, rl, rt, rs);
        check("post_to_k", rk, 6); check("post_to_l", rl, 11); check("post_to_st", rs, 0);
        check("post_to_rst", nr, 0); check("post_to_lat", lat, 7); check("post_to_tag", rt, 7);

        // Reset in the middle of WAIT drops the job
        job_if.in_a = 1; job_if.in_b = 1; job_if.in_c = 1; job_if.in_d = 1;
        job_if.in_e = 1; job_if.in_f = 1; job_if.in_g = 1;
        job_if.in_valid = 1'b1;
        @(posedge Clk); #1;
        job_if.in_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #2 Rst = 1'b0;
        #1;
        q.delete(); mtag = 0; since_acc = -1; have_ops = 1'b0;
        check("mid_rst_out_valid", job_if.out_valid, 0);
        check("mid_rst_out_k", job_if.out_k, 0);
        check("mid_rst_out_tag", job_if.out_tag, 0);
        check("mid_rst_kern_a", kern_a, 0);
        check("mid_rst_kern_rst", kern_rst, 1);
        @(negedge Clk); @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            check("dropped_no_out_valid", job_if.out_valid, 0);
        end

        run_job(10, 10, 0, 0, 4, 9, -2, 0, lat, nr, rk, rl, rt, rs);
        check("after_rst_tag", rt, 0); check("after_rst_k", rk, 25); check("after_rst_l", rl, -4);

        for (int i = 1; i <= 16; i++) begin
            run_job(word_t'(i), -1, 2, 2, 3, word_t'(i * 3), 4, 0, lat, nr, rk, rl, rt, rs);
        end
        check("tag_wrap", rt, 0);

        repeat (3) @(posedge Clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
